// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB widths, tag encoding and the CdbEntry record
// Falls back to local defaults when the common_def macros are not already defined.
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef REG_NUM_WIDTH
`define REG_NUM_WIDTH 5
`endif
`ifndef INST_TAG_WIDTH
`define INST_TAG_WIDTH 6
`endif
`ifndef TAG_INVALID
`define TAG_INVALID 6'd0
`endif

package cdb_arbiter_pkg;

  localparam int COMMON_WIDTH   = `COMMON_WIDTH;
  localparam int REG_NUM_WIDTH  = `REG_NUM_WIDTH;
  localparam int INST_TAG_WIDTH = `INST_TAG_WIDTH;
  localparam int QUEUE_DEPTH    = 2;

  typedef logic [COMMON_WIDTH-1:0]   data_t;
  typedef logic [REG_NUM_WIDTH-1:0]  reg_t;
  typedef logic [INST_TAG_WIDTH-1:0] tag_t;

  localparam tag_t TAG_INVALID = `TAG_INVALID;

  typedef struct packed {
    data_t data;
    reg_t  reg_idx;
    tag_t  tag;
  } CdbEntry;

  // Idle broadcast must target r0 with data 0 and a tag no station can match.
  localparam CdbEntry IDLE_ENTRY = '{data: '0, reg_idx: '0, tag: TAG_INVALID};

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - functional-unit result ports and CDB broadcast bundle
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int SRC_NUM = 4
);

  logic [SRC_NUM-1:0] src_valid;
  logic [SRC_NUM-1:0] src_ready;
  data_t              src_data [SRC_NUM];
  reg_t               src_reg  [SRC_NUM];
  tag_t               src_tag  [SRC_NUM];

  logic               cdb_valid;
  data_t              wd;
  reg_t               wr;
  tag_t               w_tag;

  modport master (
    output src_valid, src_data, src_reg, src_tag,
    input  src_ready, cdb_valid, wd, wr, w_tag
  );

  modport slave (
    input  src_valid, src_data, src_reg, src_tag,
    output src_ready, cdb_valid, wd, wr, w_tag
  );

endinterface

// File: rtl/cdb_src_queue.sv
// rtl/cdb_src_queue.sv - 2-entry per-source result FIFO cleared by rst_tag
module cdb_src_queue
  import cdb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_tag,
  input  logic    push,
  input  logic    pop,
  input  CdbEntry push_entry,
  output CdbEntry head,
  output logic    empty,
  output logic    ready
);

  CdbEntry    slot_q [QUEUE_DEPTH];
  CdbEntry    slot_d [QUEUE_DEPTH];
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       wr_ptr;

  always_comb begin
    slot_d   = slot_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Two slots, so the tail sits one past the head exactly when count is odd.
    wr_ptr   = rd_ptr_q ^ count_q[0];
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push) begin
      slot_d[wr_ptr] = push_entry;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_tag) begin
    if (rst_tag) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        slot_q[i] <= IDLE_ENTRY;
      end
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      slot_q   <= slot_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = slot_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign ready = (count_q != 2'd2);

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB write-back arbiter with registered broadcast
// Optional same-cycle bypass of empty queues: CDB_BYPASS_EN.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int SRC_NUM = 4
)(
  input logic           clk,
  input logic           rst_tag,
  cdb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(SRC_NUM);

  logic [SRC_NUM-1:0]   q_empty, q_ready, push, pop, req, byp;
  logic [2*SRC_NUM-1:0] req2;
  CdbEntry              head     [SRC_NUM];
  CdbEntry              in_entry [SRC_NUM];
  logic [PTR_W-1:0]     rr_q, rr_d, win;
  logic                 win_found;
  logic                 cdb_valid_q, cdb_valid_d;
  CdbEntry              bcast_q, bcast_d;

  for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
    assign in_entry[i] = '{data: bus.src_data[i], reg_idx: bus.src_reg[i], tag: bus.src_tag[i]};
    assign bus.src_ready[i] = q_ready[i];

    cdb_src_queue u_queue (
      .clk        (clk),
      .rst_tag    (rst_tag),
      .push       (push[i]),
      .pop        (pop[i]),
      .push_entry (in_entry[i]),
      .head       (head[i]),
      .empty      (q_empty[i]),
      .ready      (q_ready[i])
    );
  end

  always_comb begin
    byp = '0;
`ifdef CDB_BYPASS_EN
    // An empty queue lets a fresh valid result compete directly this cycle.
    for (int i = 0; i < SRC_NUM; i++) begin
      byp[i] = q_empty[i] && bus.src_valid[i] && (bus.src_tag[i] != TAG_INVALID);
    end
`endif
    req  = ~q_empty | byp;
    req2 = {req, req} >> rr_q;

    win_found = 1'b0;
    win       = '0;
    for (int k = 0; k < SRC_NUM; k++) begin
      if (!win_found && req2[k]) begin
        win_found = 1'b1;
        win       = PTR_W'((int'(rr_q) + k) % SRC_NUM);
      end
    end

    for (int i = 0; i < SRC_NUM; i++) begin
      pop[i]  = win_found && (win == PTR_W'(i)) && !q_empty[i];
      // Invalid-tag results complete the handshake but are never stored.
      push[i] = bus.src_valid[i] && q_ready[i] && (bus.src_tag[i] != TAG_INVALID)
                && !(win_found && (win == PTR_W'(i)) && byp[i]);
    end

    if (win_found) begin
      cdb_valid_d = 1'b1;
      bcast_d     = q_empty[win] ? in_entry[win] : head[win];
      rr_d        = (int'(win) == SRC_NUM - 1) ? '0 : win + PTR_W'(1);
    end else begin
      cdb_valid_d = 1'b0;
      bcast_d     = IDLE_ENTRY;
      rr_d        = rr_q;
    end
  end

  always_ff @(posedge clk or posedge rst_tag) begin
    if (rst_tag) begin
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      bcast_q     <= IDLE_ENTRY;
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      bcast_q     <= bcast_d;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.wd        = bcast_q.data;
  assign bus.wr        = bcast_q.reg_idx;
  assign bus.w_tag     = bcast_q.tag;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter against a queue-level model
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;
`ifdef CDB_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_tag;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.SRC_NUM(N)) bus();
  cdb_arbiter #(.SRC_NUM(N)) dut (.clk(clk), .rst_tag(rst_tag), .bus(bus));

  int checks = 0;
  int errors = 0;

  CdbEntry mq [N][$];
  int      rr = 0;

  typedef struct {
    logic [N-1:0] mask;
    int           exp_src;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input data_t d, input reg_t r, input tag_t t);
    bus.src_valid[i] = v;
    bus.src_data[i]  = d;
    bus.src_reg[i]   = r;
    bus.src_tag[i]   = t;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) drive(i, 1'b0, '0, '0, TAG_INVALID);
  endtask

  // One clock: check ready against the model, advance the model, then compare the broadcast.
  task automatic cycle();
    bit           found;
    bit           byp_w;
    int           w;
    CdbEntry      e;
    bit [N-1:0]   rdy;
    found = 0;
    byp_w = 0;
    w     = 0;
    for (int i = 0; i < N; i++) begin
      rdy[i] = (mq[i].size() < 2);
      check($sformatf("src_ready%0d", i), bus.src_ready[i], rdy[i]);
    end
    for (int k = 0; k < N; k++) begin
      int  i;
      bit  cand;
      i    = (rr + k) % N;
      cand = (mq[i].size() > 0);
`ifdef CDB_BYPASS_EN
      if (mq[i].size() == 0 && bus.src_valid[i] && bus.src_tag[i] != TAG_INVALID) cand = 1;
`endif
      if (!found && cand) begin
        found = 1;
        w     = i;
      end
    end
    if (found) begin
      if (mq[w].size() > 0) e = mq[w].pop_front();
      else begin
        e     = '{data: bus.src_data[w], reg_idx: bus.src_reg[w], tag: bus.src_tag[w]};
        byp_w = 1;
      end
      rr = (w + 1) % N;
    end else begin
      e = '{data: '0, reg_idx: '0, tag: TAG_INVALID};
    end
    for (int i = 0; i < N; i++) begin
      if (bus.src_valid[i] && rdy[i] && bus.src_tag[i] != TAG_INVALID && !(byp_w && w == i))
        mq[i].push_back('{data: bus.src_data[i], reg_idx: bus.src_reg[i], tag: bus.src_tag[i]});
    end
    @(posedge clk);
    #1;
    check("cdb_valid", bus.cdb_valid, found);
    check("wd", bus.wd, e.data);
    check("wr", bus.wr, e.reg_idx);
    check("w_tag", bus.w_tag, e.tag);
  endtask

  task automatic check_idle(input string name);
    check({name, "_valid"}, bus.cdb_valid, 1'b0);
    check({name, "_wd"}, bus.wd, '0);
    check({name, "_wr"}, bus.wr, '0);
    check({name, "_tag"}, bus.w_tag, TAG_INVALID);
  endtask

  // Asserts rst_tag between edges; outputs must go idle without waiting for a clock.
  task automatic flush_mid();
    #3 rst_tag = 1'b1;
    #1;
    check_idle("flush");
    for (int i = 0; i < N; i++) check($sformatf("flush_ready%0d", i), bus.src_ready[i], 1'b1);
    for (int i = 0; i < N; i++) mq[i].delete();
    rr = 0;
    @(posedge clk);
    #1;
    rst_tag = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   s0, s1;
    bit   seen_low, hs0, hs1;
    tag_t log_q [$];

`ifdef CDB_BYPASS_EN
    tbl[0] = '{4'hF, 0}; tbl[1] = '{4'h0, 1}; tbl[2] = '{4'h0, 2};
    tbl[3] = '{4'h0, 3}; tbl[4] = '{4'h0, -1}; tbl[5] = '{4'h0, -1};
`else
    tbl[0] = '{4'hF, -1}; tbl[1] = '{4'h0, 0}; tbl[2] = '{4'h0, 1};
    tbl[3] = '{4'h0, 2}; tbl[4] = '{4'h0, 3}; tbl[5] = '{4'h0, -1};
`endif

    rst_tag = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    for (int i = 0; i < N; i++) check($sformatf("reset_ready%0d", i), bus.src_ready[i], 1'b1);
    rst_tag = 1'b0;

    // Single result from source 2.
    drive(2, 1'b1, 32'hDEADBEEF, 5'd5, 6'd3);
    cycle();
    idle_inputs();
    check("single_n_valid", bus.cdb_valid, LAT == 0);
    check("single_n_tag", bus.w_tag, (LAT == 0) ? 6'd3 : TAG_INVALID);
    cycle();
    check("single_n1_valid", bus.cdb_valid, LAT == 1);
    check("single_n1_wd", bus.wd, (LAT == 1) ? 32'hDEADBEEF : 32'h0);
    cycle();
    check("single_n2_valid", bus.cdb_valid, 1'b0);

    // Contention from a known rr pointer of 0.
    flush_mid();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        drive(i, tbl[r].mask[i], 32'hC0DE0000 | i, reg_t'(i + 1), tag_t'(i + 8));
      cycle();
      check($sformatf("tbl%0d_valid", r), bus.cdb_valid, tbl[r].exp_src >= 0);
      if (tbl[r].exp_src >= 0) begin
        check($sformatf("tbl%0d_tag", r), bus.w_tag, tag_t'(tbl[r].exp_src + 8));
        check($sformatf("tbl%0d_wd", r), bus.wd, 32'hC0DE0000 | tbl[r].exp_src);
      end else begin
        check($sformatf("tbl%0d_tag", r), bus.w_tag, TAG_INVALID);
      end
    end

    // Invalid tag: handshake completes, nothing broadcast.
    idle_inputs();
    drive(3, 1'b1, 32'h123, 5'd7, TAG_INVALID);
    check("inv_ready", bus.src_ready[3], 1'b1);
    cycle();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      check("inv_valid", bus.cdb_valid, 1'b0);
      check("inv_ready_after", bus.src_ready[3], 1'b1);
      cycle();
    end

    // Backpressure: source 1 holds four results while source 0 competes every cycle.
    flush_mid();
    s0 = 0; s1 = 0; seen_low = 0;
    for (int c = 0; c < 16; c++) begin
      drive(0, 1'b1, 32'h0A00 + s0, 5'd1, tag_t'(40 + (s0 % 20)));
      if (s1 < 4) drive(1, 1'b1, 32'h1B00 + s1, 5'd2, tag_t'(20 + s1));
      else        drive(1, 1'b0, '0, '0, TAG_INVALID);
      hs0 = bus.src_ready[0];
      hs1 = bus.src_valid[1] && bus.src_ready[1];
      if (!bus.src_ready[1] && s1 < 4) seen_low = 1;
      cycle();
      if (hs0) s0++;
      if (hs1) s1++;
      if (bus.cdb_valid && bus.w_tag >= 20 && bus.w_tag <= 23) log_q.push_back(bus.w_tag);
    end
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (bus.cdb_valid && bus.w_tag >= 20 && bus.w_tag <= 23) log_q.push_back(bus.w_tag);
    end
    check("bp_accepted", s1, 4);
    check("bp_ready_dropped", seen_low, 1'b1);
    check("bp_count", log_q.size(), 4);
    for (int k = 0; k < log_q.size(); k++) check($sformatf("bp_order%0d", k), log_q[k], tag_t'(20 + k));

    // Flush with three non-empty queues: nothing pending survives.
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 3; i++) drive(i, 1'b1, 32'h5000 + i, 5'd9, tag_t'(50 + 3 * c + i));
      cycle();
    end
    idle_inputs();
    flush_mid();
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("post_flush_valid", bus.cdb_valid, 1'b0);
    end

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        drive(i, $urandom_range(0, 99) < 55, $urandom, reg_t'($urandom_range(0, 31)),
              tag_t'($urandom_range(0, 63)));
      if (c % 151 == 150) flush_mid();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Write-back arbiter for the out-of-order core's common data bus (CDB). Collects completed results (data, destination register, instruction tag) from up to SRC_NUM functional units through per-source 2-entry queues, selects one per cycle round-robin, and drives the registered broadcast (wd, wr, w_tag) consumed by the register file and the reservation stations. A tag flush (rst_tag) discards every pending result.

## Interface
- SRC_NUM, 4: number of functional-unit sources; 2..8.
- QUEUE_DEPTH, 2: entries per source queue; fixed at 2 and not overridable.
- clk  in  1  clock; all state updates on posedge.
- rst_tag  in  1  reset rst_tag, asynchronous, active-high; flushes queues and idles outputs.
- src_valid [0:SRC_NUM-1]  in  1  result offered by source i.
- src_ready [0:SRC_NUM-1]  out  1  source i queue can accept; transfer when valid && ready at posedge.
- src_data [0:SRC_NUM-1]  in  `COMMON_WIDTH  result value.
- src_reg [0:SRC_NUM-1]  in  `REG_NUM_WIDTH  destination architectural register.
- src_tag [0:SRC_NUM-1]  in  `INST_TAG_WIDTH  producing instruction tag.
- cdb_valid  out  1  broadcast valid this cycle.
- wd  out  `COMMON_WIDTH  broadcast data.
- wr  out  `REG_NUM_WIDTH  broadcast destination register.
- w_tag  out  `INST_TAG_WIDTH  broadcast tag.

## Operation
- Per source: FIFO of QUEUE_DEPTH entries {data, reg, tag}; count 0..2.
- src_ready = (count < 2); depends only on queue state, never on src_valid or the arbitration result.
- Push with src_tag == `TAG_INVALID: handshake completes, entry dropped, never broadcast.
- Arbitration: round-robin over non-empty queues starting at pointer rr_ptr; winner w is popped; rr_ptr <= (w+1) mod SRC_NUM. No winner: rr_ptr holds.
- Broadcast registers: with a winner, cdb_valid=1, wd/wr/w_tag = winner head. With no winner: cdb_valid=0, wd=0, wr=0, w_tag=`TAG_INVALID. Idle values are mandatory: the register file writes whenever w_tag matches an entry tag, so idle must target r0 with data 0.
- Simultaneous push and pop on one queue: both take effect, count unchanged; order preserved (FIFO).
- Push to a full queue is impossible (ready low); a queue full at an edge where it is also popped still reports ready low that cycle.
- rst_tag asserted (any time, including mid-broadcast): all counts 0, rr_ptr 0, outputs to idle values immediately; src_ready all 1 after release. Inputs ignored while asserted.

## Timing
- Reset values: cdb_valid 0, wd 0, wr 0, w_tag `TAG_INVALID, src_ready all 1.
- Default latency: result accepted at edge N is broadcast no earlier than after edge N+1 (1 cycle in queue minimum).
- Throughput: one broadcast per cycle; each source sustains one result per cycle while it wins every cycle.
- Fairness: a non-empty queue waits at most SRC_NUM-1 broadcasts.

## Configuration
- CDB_BYPASS_EN defined: a source whose queue is empty and which offers a valid result participates in arbitration the same cycle; if it wins, the result goes onto the broadcast registers at the acceptance edge N (visible after edge N), bypassing the queue. Loss: result enqueued normally. Priority rule unchanged (rr_ptr order; queued heads and bypass candidates compete identically, one candidate per source).
- Not defined: no bypass; minimum latency as stated in Timing.

## Structure
- `COMMON_WIDTH, `REG_NUM_WIDTH, `INST_TAG_WIDTH, `TAG_INVALID come from the shared common_def.h; a CdbEntry typedef {data, reg, tag} is added there for reuse by reservation stations.
- Sub-module cdb_src_queue: 2-entry FIFO with push/pop/count, async rst_tag clear; instantiated SRC_NUM times. Arbiter and broadcast registers live in cdb_arbiter.

## Test plan
- Reset: assert rst_tag -> cdb_valid 0, wr 0, wd 0, w_tag `TAG_INVALID, all src_ready 1.
- Single result: src 2 offers data 0xDEADBEEF, reg 5, tag 3 at edge N -> broadcast visible after edge N+1 (after edge N with CDB_BYPASS_EN), one cycle only.
- Contention: sources 0..3 each offer one result same edge, rr_ptr 0 -> broadcasts in order 0,1,2,3 on consecutive cycles, then idle values.
- Backpressure: source 1 holds valid for 4 results while source 0 competes every cycle -> source 1 src_ready drops after 2 queued, broadcasts alternate 0,1,0,1, no loss, order preserved.
- Invalid tag: source 3 offers tag `TAG_INVALID -> handshake completes, no broadcast, cdb_valid stays 0.
- Flush: 3 queues non-empty, assert rst_tag mid-cycle -> outputs idle immediately, none of the pending results ever broadcast after release.
